// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned MD_W = 32;
    localparam logic [MD_W-1:0] MOST_NEG = {1'b1, {(MD_W-1){1'b0}}};

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the register-read stage and the muldiv unit.
interface muldiv_if #(
    parameter int W = 32
) ();

    logic         start;
    logic [2:0]   funct3;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic [4:0]   rd_in;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic [4:0]   rd_out;
    logic         reg_write;

    modport master (
        output start, funct3, op_a, op_b, rd_in,
        input  busy, done, result, rd_out, reg_write
    );

    modport slave (
        input  start, funct3, op_a, op_b, rd_in,
        output busy, done, result, rd_out, reg_write
    );

endinterface

// File: rtl/muldiv_unit.sv
// Iterative radix-2 RV32M multiply/divide: one shift-add or shift-subtract step per clock,
// both sharing a single 2W-bit accumulator.
//
// state | meaning
// IDLE  | waiting for start; also the cycle in which done is pulsed
// RUN   | W iterations, counter counts W down to 0
// DONE  | sign correction / special-case override, result registered at exit
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int W = 32
) (
    input  logic    clock,
    input  logic    reset,
    muldiv_if.slave bus
);

    localparam int CW = $clog2(W + 1);
    localparam logic [W-1:0] MOST_NEG_W = {1'b1, {(W-1){1'b0}}};

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q;
    logic [2:0]     f3_q;
    logic [4:0]     rd_q;
    logic [2*W-1:0] acc_q;
    logic [W-1:0]   opnd_q;
    logic [W-1:0]   a_raw_q;
    logic [W-1:0]   result_q;
    logic           done_q;
    logic           neg_res_q;
    logic           neg_rem_q;
    logic           div0_q;
    logic           ovf_q;

    // operand conditioning at the start edge
    logic           a_signed, b_signed;
    logic           a_neg, b_neg;
    logic [W-1:0]   abs_a, abs_b;
    logic           div0, ovf;

    always_comb begin
        a_signed = 1'b1;
        b_signed = 1'b1;
        case (bus.funct3)
            F3_MULHSU: b_signed = 1'b0;
            F3_MULHU, F3_DIVU, F3_REMU: begin
                a_signed = 1'b0;
                b_signed = 1'b0;
            end
            default: ;
        endcase
    end

    assign a_neg = a_signed & bus.op_a[W-1];
    assign b_neg = b_signed & bus.op_b[W-1];
    assign abs_a = a_neg ? -bus.op_a : bus.op_a;
    assign abs_b = b_neg ? -bus.op_b : bus.op_b;
    assign div0  = (bus.op_b == '0);
    assign ovf   = ((bus.funct3 == F3_DIV) || (bus.funct3 == F3_REM))
                   && (bus.op_a == MOST_NEG_W) && (&bus.op_b);

    // one multiply step: conditional add into the high half, then shift right
    logic [W:0]     mul_sum;
    logic [2*W-1:0] mul_next;

    assign mul_sum  = {1'b0, acc_q[2*W-1:W]} + {1'b0, (acc_q[0] ? opnd_q : {W{1'b0}})};
    assign mul_next = {mul_sum, acc_q[W-1:1]};

    // one restoring divide step: shift left, trial-subtract the divisor
    logic [W:0]     rem_sh;
    logic [W:0]     rem_diff;
    logic           rem_ge;
    logic [2*W-1:0] div_next;

    assign rem_sh   = {acc_q[2*W-1:W], acc_q[W-1]};
    assign rem_diff = rem_sh - {1'b0, opnd_q};
    assign rem_ge   = (rem_sh >= {1'b0, opnd_q});
    assign div_next = rem_ge ? {rem_diff[W-1:0], acc_q[W-2:0], 1'b1}
                             : {rem_sh[W-1:0],   acc_q[W-2:0], 1'b0};

    // final result selection with sign correction and special-case overrides
    logic [2*W-1:0] prod_fix;
    logic [W-1:0]   quo_fix;
    logic [W-1:0]   rem_fix;
    logic [W-1:0]   res_fin;

    assign prod_fix = neg_res_q ? -acc_q : acc_q;
    assign quo_fix  = neg_res_q ? -acc_q[W-1:0] : acc_q[W-1:0];
    assign rem_fix  = neg_rem_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];

    always_comb begin
        res_fin = '0;
        case (f3_q)
            F3_MUL:                       res_fin = prod_fix[W-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: res_fin = prod_fix[2*W-1:W];
            F3_DIV, F3_DIVU: begin
                if (div0_q)      res_fin = '1;
                else if (ovf_q)  res_fin = MOST_NEG_W;
                else             res_fin = quo_fix;
            end
            F3_REM, F3_REMU: begin
                if (div0_q)      res_fin = a_raw_q;
                else if (ovf_q)  res_fin = '0;
                else             res_fin = rem_fix;
            end
            default: res_fin = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (cnt_q == CW'(1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.busy      = (state_q != IDLE) || done_q;
        bus.done      = done_q;
        bus.reg_write = done_q && (rd_q != 5'd0);
        bus.result    = result_q;
        bus.rd_out    = rd_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q     <= '0;
            f3_q      <= '0;
            rd_q      <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            a_raw_q   <= '0;
            result_q  <= '0;
            done_q    <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            done_q <= (state_q == DONE);
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        f3_q      <= bus.funct3;
                        rd_q      <= bus.rd_in;
                        cnt_q     <= CW'(W);
                        a_raw_q   <= bus.op_a;
                        neg_res_q <= a_neg ^ b_neg;
                        neg_rem_q <= a_neg;
                        div0_q    <= div0;
                        ovf_q     <= ovf;
                        // multiply keeps the multiplier in the low half, divide the dividend
                        if (bus.funct3[2]) begin
                            acc_q  <= {{W{1'b0}}, abs_a};
                            opnd_q <= abs_b;
                        end else begin
                            acc_q  <= {{W{1'b0}}, abs_b};
                            opnd_q <= abs_a;
                        end
                    end
                end
                RUN: begin
                    acc_q <= f3_q[2] ? div_next : mul_next;
                    cnt_q <= cnt_q - CW'(1);
                end
                DONE: result_q <= res_fin;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expectations queued at issue, checked on done.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic clock = 1'b0;
    logic reset;
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_err  = 0;
    int   n_done = 0;

    typedef struct {
        logic [W-1:0] res;
        logic [4:0]   rd;
        logic         regw;
        int           t0;
    } exp_t;

    exp_t sb_q[$];

    muldiv_if #(.W(W)) bus ();

    muldiv_unit #(.W(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [2:0] f3, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     p;
        int              ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = 64'(a);
        ub = 64'(b);
        ia = $signed(a);
        ib = $signed(b);
        model = '0;
        case (f3)
            F3_MUL:    begin p = sa * sb;             model = p[31:0];  end
            F3_MULH:   begin p = sa * sb;             model = p[63:32]; end
            F3_MULHSU: begin p = sa * longint'(ub);   model = p[63:32]; end
            F3_MULHU:  begin p = ua * ub;             model = p[63:32]; end
            F3_DIV: begin
                if (b == '0)                          model = '1;
                else if (a == MOST_NEG && b == '1)    model = a;
                else                                  model = ia / ib;
            end
            F3_DIVU:   model = (b == '0) ? '1 : a / b;
            F3_REM: begin
                if (b == '0)                          model = a;
                else if (a == MOST_NEG && b == '1)    model = '0;
                else                                  model = ia % ib;
            end
            default:   model = (b == '0) ? a : a % b;
        endcase
    endfunction

    always @(negedge clock) begin
        exp_t e;
        if (bus.done) begin
            n_done++;
            if (sb_q.size() == 0) begin
                chk("spurious_done", W'(bus.done), '0);
            end else begin
                e = sb_q.pop_front();
                chk("result", bus.result, e.res);
                chk("rd_out", W'(bus.rd_out), W'(e.rd));
                chk("reg_write", W'(bus.reg_write), W'(e.regw));
                chk("latency", W'(cyc - e.t0), W'(W + 1));
            end
        end else begin
            chk("regw_idle", W'(bus.reg_write), '0);
        end
    end

    task automatic issue(input logic [2:0] f3, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [4:0] rd, input logic [W-1:0] exp, input bit push);
        exp_t e;
        @(negedge clock);
        bus.start  = 1'b1;
        bus.funct3 = f3;
        bus.op_a   = a;
        bus.op_b   = b;
        bus.rd_in  = rd;
        @(posedge clock);
        #1;
        if (push) begin
            e.res  = exp;
            e.rd   = rd;
            e.regw = (rd != 5'd0);
            e.t0   = cyc;
            sb_q.push_back(e);
        end
        bus.start  = 1'b0;
        bus.funct3 = 3'($urandom);
        bus.op_a   = $urandom;
        bus.op_b   = $urandom;
        bus.rd_in  = 5'($urandom);
    endtask

    task automatic wait_n(input int target, input int budget);
        for (int i = 0; i < budget && n_done < target; i++) @(posedge clock);
        chk("done_count", W'(n_done), W'(target));
    endtask

    task automatic run(input logic [2:0] f3, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [4:0] rd, input logic [W-1:0] exp);
        int base;
        base = n_done;
        issue(f3, a, b, rd, exp, 1'b1);
        wait_n(base + 1, 60);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int          base;
        logic [2:0]  f3;
        logic [W-1:0] a, b, ex;
        logic [4:0]  rd;

        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.funct3 = '0;
        bus.op_a   = '0;
        bus.op_b   = '0;
        bus.rd_in  = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_busy", W'(bus.busy), '0);
        chk("rst_done", W'(bus.done), '0);
        chk("rst_result", bus.result, '0);
        chk("rst_rd_out", W'(bus.rd_out), '0);
        chk("rst_reg_write", W'(bus.reg_write), '0);
        reset = 1'b0;

        // first op with cycle-by-cycle busy tracking
        base = n_done;
        issue(F3_MUL, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 1'b1);
        for (int i = 0; i <= W + 1; i++) begin
            @(negedge clock);
            chk("busy_window", W'(bus.busy), 1);
        end
        @(negedge clock);
        chk("busy_after", W'(bus.busy), '0);
        wait_n(base + 1, 5);

        run(F3_MULH,   32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000);
        run(F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE);
        run(F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFF);
        run(F3_DIV,    32'hFFFF_FFF9, 32'd2,         5'd4, 32'hFFFF_FFFD);
        run(F3_REM,    32'hFFFF_FFF9, 32'd2,         5'd6, 32'hFFFF_FFFF);
        run(F3_DIVU,   32'd100,       32'd7,         5'd7, 32'd14);
        run(F3_REMU,   32'd100,       32'd7,         5'd8, 32'd2);
        run(F3_DIV,    32'h1234,      32'd0,         5'd9, 32'hFFFF_FFFF);
        run(F3_REMU,   32'h1234,      32'd0,         5'd10, 32'h1234);
        run(F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000);
        run(F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0);
        run(F3_REM,    32'hFFFF_FF00, 32'd0,         5'd13, 32'hFFFF_FF00);
        run(F3_MUL,    32'd6,         32'd9,         5'd0, 32'd54);

        for (int n = 0; n < 12; n++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            case ($urandom_range(0, 4))
                0:       b = '0;
                1:       b = 32'($urandom_range(1, 15));
                2: begin a = MOST_NEG; b = '1; end
                default: b = $urandom;
            endcase
            rd = 5'($urandom);
            run(f3, a, b, rd, model(f3, a, b));
        end

        // start re-pulsed mid-run must be ignored
        base = n_done;
        issue(F3_DIVU, 32'd1000, 32'd33, 5'd14, 32'd30, 1'b1);
        repeat (4) @(posedge clock);
        issue(F3_MUL, 32'd2, 32'd2, 5'd15, 32'd0, 1'b0);
        repeat (14) @(posedge clock);
        issue(F3_MUL, 32'd3, 32'd3, 5'd16, 32'd0, 1'b0);
        wait_n(base + 1, 60);
        repeat (40) @(posedge clock);
        chk("no_extra_done", W'(n_done), W'(base + 1));

        // start held high: acceptance every W+2 cycles
        base = n_done;
        ex   = model(F3_MULHU, 32'h1234_5678, 32'h9ABC_DEF0);
        @(negedge clock);
        bus.start  = 1'b1;
        bus.funct3 = F3_MULHU;
        bus.op_a   = 32'h1234_5678;
        bus.op_b   = 32'h9ABC_DEF0;
        bus.rd_in  = 5'd17;
        for (int n = 0; n < 3; n++) begin
            exp_t e;
            @(posedge clock);
            #1;
            e.res = ex; e.rd = 5'd17; e.regw = 1'b1; e.t0 = cyc;
            sb_q.push_back(e);
            if (n < 2) repeat (W + 1) @(posedge clock);
        end
        bus.start = 1'b0;
        wait_n(base + 3, 60);

        // reset in the middle of a divide
        base = n_done;
        issue(F3_DIV, 32'd5000, 32'd7, 5'd18, 32'd0, 1'b0);
        repeat (9) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("rst_mid_busy", W'(bus.busy), '0);
        chk("rst_mid_result", bus.result, '0);
        chk("rst_mid_rd_out", W'(bus.rd_out), '0);
        repeat (40) @(posedge clock);
        chk("rst_no_done", W'(n_done), W'(base));
        run(F3_MUL, 32'd3, 32'd4, 5'd19, 32'd12);

        chk("sb_empty", W'(sb_q.size()), '0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
